// File: rtl/alu_button_sequencer_if.sv
// rtl/alu_button_sequencer_if.sv - operand/select/result bus between the sequencer and the ALU
//
// Purpose: bundles the signals exchanged between alu_button_sequencer and the
// combinational 8-bit signed ALU.
//
// Signals:
//   alu_a, alu_b        8  operands presented to the ALU
//   alu_u .. alu_d      1  operation select lines (one-hot or all zero)
//   alu_result          8  combinational ALU result
//
// Modports:
//   master  sequencer side (drives operands and selects, reads result)
//   slave   ALU side (reads operands and selects, drives result)

interface alu_button_sequencer_if;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_u;
  logic       alu_l;
  logic       alu_c;
  logic       alu_r;
  logic       alu_d;
  logic [7:0] alu_result;

  modport master (
    output alu_a, alu_b, alu_u, alu_l, alu_c, alu_r, alu_d,
    input  alu_result
  );

  modport slave (
    input  alu_a, alu_b, alu_u, alu_l, alu_c, alu_r, alu_d,
    output alu_result
  );
endinterface

// File: rtl/alu_button_sequencer.sv
// rtl/alu_button_sequencer.sv - button front-end sequencer for the Basys3 8-bit signed ALU
//
// Purpose: synchronizes and debounces five raw push-buttons, turns the first
// debounced press into a single ALU operation (priority U > L > C > R > D),
// holds the selected operation line high for exactly two cycles with operands
// latched from the switches, and registers the ALU result onto the LEDs.
//
// Ports:
//   clk                  system clock
//   reset                asynchronous, active-high reset
//   sw_a, sw_b      [7:0] operand sources (switches)
//   btn_u .. btn_d        raw asynchronous push-buttons
//   alu                   alu_button_sequencer_if.master: alu_a, alu_b,
//                         alu_u..alu_d out; alu_result in
//   led             [7:0] registered ALU result
//   busy                  high whenever the FSM is not in IDLE
//
// Parameters:
//   DEBOUNCE_CYCLES       stable cycles required before a debounced level
//                         changes (use 4 in simulation)
//
// Build option:
//   ACCUM_EN              when defined, operand A is latched from led instead
//                         of sw_a so results chain (accumulator mode)

module alu_button_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    sw_a,
  input  logic [7:0]                    sw_b,
  input  logic                          btn_u,
  input  logic                          btn_l,
  input  logic                          btn_c,
  input  logic                          btn_r,
  input  logic                          btn_d,
  alu_button_sequencer_if.master        alu,
  output logic [7:0]                    led,
  output logic                          busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // Button vectors are ordered by priority: bit 4 = U (highest) .. bit 0 = D.
  logic [4:0]       btn_raw;
  logic [4:0]       sync_1;
  logic [4:0]       sync_2;
  logic [4:0]       deb;
  logic [4:0]       deb_prev;
  logic [CNT_W-1:0] cnt [5];
  logic [4:0]       press;
  logic [4:0]       sel;

  logic [1:0]       state;
  logic [4:0]       op;
  logic [7:0]       opa;
  logic [7:0]       opb;
  logic             drive_op;

  assign btn_raw = {btn_u, btn_l, btn_c, btn_r, btn_d};

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 5'b0;
      sync_2 <= 5'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Debounce: any cycle where the synchronized level agrees with the
  // debounced level restarts the count, so only an uninterrupted run of
  // DEBOUNCE_CYCLES disagreeing cycles flips the debounced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb <= 5'b0;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync_2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising-edge detector on the debounced levels. deb_prev clears on reset,
  // so a button held through reset release still yields one press once its
  // debounced level rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_prev <= 5'b0;
    end else begin
      deb_prev <= deb;
    end
  end

  assign press = deb & ~deb_prev;

  // Fixed priority pick; lower-priority simultaneous presses are dropped.
  always_comb begin
    sel = 5'b0;
    if (press[4]) begin
      sel = 5'b10000;
    end else if (press[3]) begin
      sel = 5'b01000;
    end else if (press[2]) begin
      sel = 5'b00100;
    end else if (press[1]) begin
      sel = 5'b00010;
    end else if (press[0]) begin
      sel = 5'b00001;
    end
  end

  // Operation sequencer. Presses outside IDLE are simply ignored, never queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op    <= 5'b0;
      opa   <= 8'h00;
      opb   <= 8'h00;
      led   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (|press) begin
`ifdef ACCUM_EN
            opa <= led;
`else
            opa <= sw_a;
`endif
            opb   <= sw_b;
            op    <= sel;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          led   <= alu.alu_result;
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          // Wait for every button to be released so a long hold cannot
          // retrigger and a press made while busy is lost rather than queued.
          if (deb == 5'b0) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Select lines are gated by state, so they drop at once on reset and in
  // RELEASE while the operand registers keep their last values.
  assign drive_op = (state == S_EXEC) || (state == S_CAPTURE);

  assign alu.alu_a = opa;
  assign alu.alu_b = opb;
  assign alu.alu_u = drive_op & op[4];
  assign alu.alu_l = drive_op & op[3];
  assign alu.alu_c = drive_op & op[2];
  assign alu.alu_r = drive_op & op[1];
  assign alu.alu_d = drive_op & op[0];

  assign busy = (state != S_IDLE);

endmodule
